// File: rtl/input_command_decoder_if.sv
// Bus between the controller/board side and the command decoder: button pulses in,
// cursor/digit state and the board write handshake out.
interface input_command_decoder_if #(
    parameter int unsigned N_BUTTONS = 12
);
    logic [N_BUTTONS-1:0] btn_pulse;
    logic                 cell_fixed;
    logic                 wr_ready;
    logic [3:0]           cursor_row;
    logic [3:0]           cursor_col;
    logic [3:0]           sel_digit;
    logic                 wr_valid;
    logic [3:0]           wr_row;
    logic [3:0]           wr_col;
    logic [3:0]           wr_data;
    logic                 block_controller;
    logic                 err_pulse;
    logic [3:0]           aux_pulse;

    modport master (
        input  btn_pulse, cell_fixed, wr_ready,
        output cursor_row, cursor_col, sel_digit,
        output wr_valid, wr_row, wr_col, wr_data,
        output block_controller, err_pulse, aux_pulse
    );

    modport slave (
        output btn_pulse, cell_fixed, wr_ready,
        input  cursor_row, cursor_col, sel_digit,
        input  wr_valid, wr_row, wr_col, wr_data,
        input  block_controller, err_pulse, aux_pulse
    );
endinterface

// File: rtl/input_command_decoder.sv
// Turns debounced button pulses into cursor moves, digit selection and
// place/erase writes to the board memory, with a bounded wait for wr_ready.
module input_command_decoder #(
    parameter int unsigned GRID_SIZE      = 9,
    parameter int unsigned N_BUTTONS      = 12,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                      clk,
    input  logic                      reset,
    input_command_decoder_if.master   bus
);
    localparam int unsigned POS_W = 4;
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [POS_W-1:0] LAST = POS_W'(GRID_SIZE - 1);
    localparam logic [POS_W-1:0] DMAX = POS_W'(GRID_SIZE);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_t;

    state_t           r_state;
    logic [POS_W-1:0] r_row;
    logic [POS_W-1:0] r_col;
    logic [POS_W-1:0] r_digit;
    logic             r_wr_valid;
    logic [POS_W-1:0] r_wr_row;
    logic [POS_W-1:0] r_wr_col;
    logic [POS_W-1:0] r_wr_data;
    logic             r_block;
    logic             r_err;
    logic [3:0]       r_aux;
    logic [CNT_W-1:0] r_tmo_cnt;

    logic             w_up, w_down, w_left, w_right;
    logic             w_dig_inc, w_dig_dec, w_place, w_erase;
    logic [3:0]       w_aux;
    logic [POS_W-1:0] w_row_nxt;
    logic [POS_W-1:0] w_col_nxt;
    logic [POS_W-1:0] w_digit_nxt;

    assign w_up      = bus.btn_pulse[0];
    assign w_down    = bus.btn_pulse[1];
    assign w_left    = bus.btn_pulse[2];
    assign w_right   = bus.btn_pulse[3];
    assign w_dig_inc = bus.btn_pulse[4];
    assign w_dig_dec = bus.btn_pulse[5];
    assign w_place   = bus.btn_pulse[6];
    assign w_erase   = bus.btn_pulse[7];
    assign w_aux     = bus.btn_pulse[N_BUTTONS-1 -: 4];

    // Wrapping cursor and digit steps; opposing pulses in one cycle cancel
    always_comb begin
        w_row_nxt   = r_row;
        w_col_nxt   = r_col;
        w_digit_nxt = r_digit;
        if (w_up && !w_down) begin
            w_row_nxt = (r_row == '0) ? LAST : r_row - POS_W'(1);
        end else if (w_down && !w_up) begin
            w_row_nxt = (r_row == LAST) ? '0 : r_row + POS_W'(1);
        end
        if (w_left && !w_right) begin
            w_col_nxt = (r_col == '0) ? LAST : r_col - POS_W'(1);
        end else if (w_right && !w_left) begin
            w_col_nxt = (r_col == LAST) ? '0 : r_col + POS_W'(1);
        end
        if (w_dig_inc && !w_dig_dec) begin
            w_digit_nxt = (r_digit == DMAX) ? POS_W'(1) : r_digit + POS_W'(1);
        end else if (w_dig_dec && !w_dig_inc) begin
            w_digit_nxt = (r_digit == POS_W'(1)) ? DMAX : r_digit - POS_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_row      <= '0;
            r_col      <= '0;
            r_digit    <= POS_W'(1);
            r_wr_valid <= 1'b0;
            r_wr_row   <= '0;
            r_wr_col   <= '0;
            r_wr_data  <= '0;
            r_block    <= 1'b0;
            r_err      <= 1'b0;
            r_aux      <= '0;
            r_tmo_cnt  <= '0;
        end else begin
            r_err <= 1'b0;
            r_aux <= w_aux;
            case (r_state)
                ST_IDLE: begin
                    r_row   <= w_row_nxt;
                    r_col   <= w_col_nxt;
                    r_digit <= w_digit_nxt;
                    if (w_place || w_erase) begin
                        if ((w_place && w_erase) || bus.cell_fixed) begin
                            r_err <= 1'b1;
                        end else begin
                            // Write target is the cursor before this cycle's move
                            r_state    <= ST_REQ;
                            r_wr_valid <= 1'b1;
                            r_block    <= 1'b1;
                            r_wr_row   <= r_row;
                            r_wr_col   <= r_col;
                            r_wr_data  <= w_place ? r_digit : '0;
                            r_tmo_cnt  <= '0;
                        end
                    end
                end
                ST_REQ: begin
                    if (bus.wr_ready) begin
                        r_state    <= ST_IDLE;
                        r_wr_valid <= 1'b0;
                        r_block    <= 1'b0;
                    end else if (r_tmo_cnt == TMO_LAST) begin
                        r_state    <= ST_IDLE;
                        r_wr_valid <= 1'b0;
                        r_block    <= 1'b0;
                        r_err      <= 1'b1;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_wr_valid <= 1'b0;
                    r_block    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cursor_row       = r_row;
    assign bus.cursor_col       = r_col;
    assign bus.sel_digit        = r_digit;
    assign bus.wr_valid         = r_wr_valid;
    assign bus.wr_row           = r_wr_row;
    assign bus.wr_col           = r_wr_col;
    assign bus.wr_data          = r_wr_data;
    assign bus.block_controller = r_block;
    assign bus.err_pulse        = r_err;
    assign bus.aux_pulse        = r_aux;
endmodule

// File: tb/tb_input_command_decoder.sv
// Bench for input_command_decoder: directed scenarios followed by random pulses,
// every cycle compared against a cycle-level game model.
module tb_input_command_decoder;
    localparam int G  = 9;
    localparam int TO = 8;
    localparam int B_UP = 0, B_DOWN = 1, B_LEFT = 2, B_RIGHT = 3;
    localparam int B_DINC = 4, B_DDEC = 5, B_PLACE = 6, B_ERASE = 7;

    logic clk = 1'b0;
    logic reset = 1'b1;
    input_command_decoder_if #(.N_BUTTONS(12)) bus ();

    input_command_decoder #(
        .GRID_SIZE(G), .N_BUTTONS(12), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model of the decoder's visible state
    int m_row, m_col, m_dig, m_wr_row, m_wr_col, m_wr_data, m_age, m_aux;
    bit m_busy, m_err;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [11:0] b(input int idx);
        logic [11:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    task automatic step(input bit rst, input logic [11:0] btn, input bit fixed, input bit rdy);
        int dr, dc, dd;
        bit place, erase;
        reset = rst;
        bus.btn_pulse = btn;
        bus.cell_fixed = fixed;
        bus.wr_ready = rdy;
        m_err = 0;
        m_aux = int'(btn[11:8]);
        if (rst) begin
            m_row = 0; m_col = 0; m_dig = 1; m_busy = 0; m_age = 0;
            m_wr_row = 0; m_wr_col = 0; m_wr_data = 0; m_aux = 0;
        end else if (!m_busy) begin
            place = btn[B_PLACE];
            erase = btn[B_ERASE];
            if (place || erase) begin
                if ((place && erase) || fixed) begin
                    m_err = 1;
                end else begin
                    m_busy = 1; m_age = 0;
                    m_wr_row = m_row; m_wr_col = m_col;
                    m_wr_data = place ? m_dig : 0;
                end
            end
            dr = int'(btn[B_DOWN]) - int'(btn[B_UP]);
            dc = int'(btn[B_RIGHT]) - int'(btn[B_LEFT]);
            dd = int'(btn[B_DINC]) - int'(btn[B_DDEC]);
            m_row = (m_row + dr + G) % G;
            m_col = (m_col + dc + G) % G;
            m_dig = ((m_dig - 1 + dd + G) % G) + 1;
        end else begin
            m_age++;
            if (rdy) m_busy = 0;
            else if (m_age == TO) begin m_busy = 0; m_err = 1; end
        end
        @(posedge clk);
        #1;
        check_eq("row",   int'(bus.cursor_row), m_row);
        check_eq("col",   int'(bus.cursor_col), m_col);
        check_eq("digit", int'(bus.sel_digit), m_dig);
        check_eq("wr_valid", int'(bus.wr_valid), int'(m_busy));
        check_eq("block", int'(bus.block_controller), int'(m_busy));
        check_eq("wr_row",  int'(bus.wr_row), m_wr_row);
        check_eq("wr_col",  int'(bus.wr_col), m_wr_col);
        check_eq("wr_data", int'(bus.wr_data), m_wr_data);
        check_eq("err", int'(bus.err_pulse), int'(m_err));
        check_eq("aux", int'(bus.aux_pulse), m_aux);
    endtask

    initial begin
        int hi_cycles, saved_row;
        logic [11:0] rb;
        bus.btn_pulse = '0;
        bus.cell_fixed = 1'b0;
        bus.wr_ready = 1'b0;

        step(1, '0, 0, 0);
        step(1, '0, 0, 0);
        check_eq("rst_digit", int'(bus.sel_digit), 1);

        step(0, b(B_UP), 0, 0);
        check_eq("up_wrap", int'(bus.cursor_row), 8);
        for (int i = 0; i < 9; i++) step(0, b(B_RIGHT), 0, 0);
        check_eq("right9", int'(bus.cursor_col), 0);
        step(0, b(B_UP) | b(B_DOWN), 0, 0);
        check_eq("updown", int'(bus.cursor_row), 8);
        step(0, b(B_DDEC), 0, 0);
        check_eq("dig_wrap", int'(bus.sel_digit), 9);

        // Move to (2,3), digit 5, place
        for (int i = 0; i < 3; i++) step(0, b(B_DOWN) | b(B_RIGHT), 0, 0);
        for (int i = 0; i < 5; i++) step(0, b(B_DINC), 0, 0);
        step(0, b(B_PLACE), 0, 0);
        check_eq("pl_valid", int'(bus.wr_valid), 1);
        check_eq("pl_row",   int'(bus.wr_row), 2);
        check_eq("pl_col",   int'(bus.wr_col), 3);
        check_eq("pl_data",  int'(bus.wr_data), 5);
        check_eq("pl_block", int'(bus.block_controller), 1);
        step(0, '0, 0, 0);
        step(0, '0, 0, 0);
        step(0, '0, 0, 1);
        check_eq("pl_done", int'(bus.wr_valid), 0);

        step(0, b(B_ERASE), 1, 0);
        check_eq("fx_err", int'(bus.err_pulse), 1);
        check_eq("fx_valid", int'(bus.wr_valid), 0);
        step(0, '0, 0, 0);
        check_eq("fx_err_1cyc", int'(bus.err_pulse), 0);

        // Timeout with up pulses ignored while busy
        saved_row = int'(bus.cursor_row);
        hi_cycles = 0;
        step(0, b(B_PLACE), 0, 0);
        for (int i = 0; i < 20 && bus.wr_valid; i++) begin
            hi_cycles++;
            step(0, b(B_UP), 0, 0);
        end
        check_eq("to_cycles", hi_cycles, TO);
        check_eq("to_err", int'(bus.err_pulse), 1);
        check_eq("to_row", int'(bus.cursor_row), saved_row);

        step(0, b(9), 0, 0);
        check_eq("aux_idle", int'(bus.aux_pulse), 2);
        step(0, b(B_PLACE), 0, 0);
        step(0, b(9), 0, 0);
        check_eq("aux_req", int'(bus.aux_pulse), 2);
        step(1, '0, 0, 0);
        check_eq("rst_valid", int'(bus.wr_valid), 0);
        check_eq("rst_block", int'(bus.block_controller), 0);
        check_eq("rst_row", int'(bus.cursor_row), 0);
        check_eq("rst_col", int'(bus.cursor_col), 0);

        for (int i = 0; i < 3000; i++) begin
            rb = '0;
            for (int k = 0; k < 12; k++) rb[k] = ($urandom_range(0, 5) == 0);
            step($urandom_range(0, 199) == 0, rb, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 9) < 3);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
